// File: rtl/rf_pkg.sv
// ============================================================================
// Package : rf_pkg
// Default sizing, write-request type and address helper for reg_file_mp
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_REGS  = 32;
  localparam int NUM_RD    = 2;

  typedef struct packed {
    logic                 en;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] data;
  } wr_req_t;

  // True when the address names a real, writable register.
  function automatic logic rf_addr_ok(input int unsigned addr,
                                      input int unsigned num_regs,
                                      input int          zero_reg);
    return (addr < num_regs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module : rf_read_port
// One registered read port: decode, write-first bypass, range check, hazard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_read_port #(
  parameter int WORD_SIZE = rf_pkg::WORD_SIZE,
  parameter int ADDR_W    = rf_pkg::ADDR_W,
  parameter int NUM_REGS  = rf_pkg::NUM_REGS,
  parameter int ZERO_REG  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [NUM_REGS*WORD_SIZE-1:0] regs_flat,
  input  logic [NUM_REGS-1:0]           busy,
  input  logic                          wr0_en,
  input  logic [ADDR_W-1:0]             wr0_addr,
  input  logic [WORD_SIZE-1:0]          wr0_data,
  input  logic                          wr1_en,
  input  logic [ADDR_W-1:0]             wr1_addr,
  input  logic [WORD_SIZE-1:0]          wr1_data,
  output logic [WORD_SIZE-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          rd_hazard
);

  import rf_pkg::*;

  logic                 w_addr_ok;
  logic                 w_hit0;
  logic                 w_hit1;
  logic                 w_busy;
  logic                 w_hazard;
  logic [WORD_SIZE-1:0] w_stored;
  logic [WORD_SIZE-1:0] w_data;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_hazard;

  always_comb begin
    w_stored = '0;
    w_busy   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        w_stored = regs_flat[i*WORD_SIZE +: WORD_SIZE];
        w_busy   = busy[i];
      end
    end
  end

  assign w_addr_ok = rf_addr_ok(32'(rd_addr), NUM_REGS, ZERO_REG);
  // Write enables arrive already qualified, so a hit is always a real write.
  assign w_hit0    = wr0_en && (wr0_addr == rd_addr);
  assign w_hit1    = wr1_en && (wr1_addr == rd_addr);
  assign w_hazard  = w_addr_ok && w_busy && !(w_hit0 || w_hit1);

  always_comb begin
    w_data = w_stored;
    if (!w_addr_ok)  w_data = '0;
    else if (w_hit1) w_data = wr1_data;
    else if (w_hit0) w_data = wr0_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_hazard <= 1'b0;
    end else begin
      r_valid  <= rd_en;
      r_hazard <= rd_en && w_hazard;
      if (rd_en) r_data <= w_data;
    end
  end

  assign rd_data   = r_data;
  assign rd_valid  = r_valid;
  assign rd_hazard = r_hazard;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module : reg_file_mp
// Multi-read, dual-write register file with a busy-bit scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_file_mp #(
  parameter int WORD_SIZE = rf_pkg::WORD_SIZE,
  parameter int ADDR_W    = rf_pkg::ADDR_W,
  parameter int NUM_REGS  = rf_pkg::NUM_REGS,
  parameter int NUM_RD    = rf_pkg::NUM_RD,
  parameter int ZERO_REG  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_valid,
  output logic [NUM_RD-1:0]           rd_hazard,
  input  logic                        wr0_en,
  input  logic [ADDR_W-1:0]           wr0_addr,
  input  logic [WORD_SIZE-1:0]        wr0_data,
  input  logic                        wr1_en,
  input  logic [ADDR_W-1:0]           wr1_addr,
  input  logic [WORD_SIZE-1:0]        wr1_data,
  input  logic                        resv_en,
  input  logic [ADDR_W-1:0]           resv_addr,
  output logic [NUM_REGS-1:0]         busy
);

  import rf_pkg::*;

  logic [WORD_SIZE-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]           r_busy;
  logic [NUM_REGS-1:0]           w_busy_nxt;
  logic [NUM_REGS*WORD_SIZE-1:0] w_regs_flat;
  logic                          w_wr0_ok;
  logic                          w_wr1_ok;
  logic                          w_resv_ok;

  assign w_wr0_ok  = wr0_en  && rf_addr_ok(32'(wr0_addr),  NUM_REGS, ZERO_REG);
  assign w_wr1_ok  = wr1_en  && rf_addr_ok(32'(wr1_addr),  NUM_REGS, ZERO_REG);
  assign w_resv_ok = resv_en && rf_addr_ok(32'(resv_addr), NUM_REGS, ZERO_REG);

  // Clear for completing writes first, then set for a new producer so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((w_wr0_ok && (wr0_addr == ADDR_W'(i))) ||
          (w_wr1_ok && (wr1_addr == ADDR_W'(i))))
        w_busy_nxt[i] = 1'b0;
      if (w_resv_ok && (resv_addr == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr1_ok && (wr1_addr == ADDR_W'(i)))
          r_regs[i] <= wr1_data;
        else if (w_wr0_ok && (wr0_addr == ADDR_W'(i)))
          r_regs[i] <= wr0_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign w_regs_flat[gi*WORD_SIZE +: WORD_SIZE] = r_regs[gi];
    end
  endgenerate

  generate
    for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rd
      rf_read_port #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .ZERO_REG  (ZERO_REG)
      ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en[gp]),
        .rd_addr   (rd_addr[gp*ADDR_W +: ADDR_W]),
        .regs_flat (w_regs_flat),
        .busy      (r_busy),
        .wr0_en    (w_wr0_ok),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (w_wr1_ok),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .rd_data   (rd_data[gp*WORD_SIZE +: WORD_SIZE]),
        .rd_valid  (rd_valid[gp]),
        .rd_hazard (rd_hazard[gp])
      );
    end
  endgenerate

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module : tb_reg_file_mp
// Directed bench for reg_file_mp against a behavioural register-file model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

  import rf_pkg::*;

  localparam int NR = 28;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_hazard;
  wr_req_t     w0;
  wr_req_t     w1;
  logic        resv_en;
  logic [4:0]  resv_addr;
  logic [NR-1:0] busy;

  logic [31:0]   m_mem [NR];
  logic [NR-1:0] m_busy;
  logic [31:0]   e_data [2];
  logic [1:0]    e_valid;
  logic [1:0]    e_haz;

  int n_tests;
  int n_fail;

  reg_file_mp #(
    .WORD_SIZE (32),
    .ADDR_W    (5),
    .NUM_REGS  (NR),
    .NUM_RD    (2),
    .ZERO_REG  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_hazard (rd_hazard),
    .wr0_en    (w0.en),
    .wr0_addr  (w0.addr),
    .wr0_data  (w0.data),
    .wr1_en    (w1.en),
    .wr1_addr  (w1.addr),
    .wr1_data  (w1.data),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic bit ok(input logic [4:0] a);
    return (int'(a) < NR) && (a != 5'd0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_busy  = '0;
    e_data[0] = '0;
    e_data[1] = '0;
    e_valid = '0;
    e_haz   = '0;
  endtask

  task automatic idle();
    rd_en     = '0;
    rd_addr   = '0;
    w0        = '0;
    w1        = '0;
    resv_en   = 1'b0;
    resv_addr = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_en[p]         = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic setw(input int which, input logic [4:0] a, input logic [31:0] d);
    if (which == 0) begin w0.en = 1'b1; w0.addr = a; w0.data = d; end
    else            begin w1.en = 1'b1; w1.addr = a; w1.data = d; end
  endtask

  // Predict from pre-edge state and inputs, clock once, then compare.
  task automatic step();
    logic [4:0] a;
    bit hit0, hit1;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      if (rd_en[p]) begin
        hit0 = w0.en && ok(w0.addr) && (w0.addr == a);
        hit1 = w1.en && ok(w1.addr) && (w1.addr == a);
        e_valid[p] = 1'b1;
        if (!ok(a))    e_data[p] = '0;
        else if (hit1) e_data[p] = w1.data;
        else if (hit0) e_data[p] = w0.data;
        else           e_data[p] = m_mem[a];
        e_haz[p] = ok(a) && m_busy[a] && !hit0 && !hit1;
      end else begin
        e_valid[p] = 1'b0;
        e_haz[p]   = 1'b0;
      end
    end
    if (w0.en && ok(w0.addr)) begin m_mem[w0.addr] = w0.data; m_busy[w0.addr] = 1'b0; end
    if (w1.en && ok(w1.addr)) begin m_mem[w1.addr] = w1.data; m_busy[w1.addr] = 1'b0; end
    if (resv_en && ok(resv_addr)) m_busy[resv_addr] = 1'b1;

    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("valid%0d", p), 64'(rd_valid[p]), 64'(e_valid[p]));
      chk($sformatf("data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(e_data[p]));
      if (e_valid[p]) chk($sformatf("hazard%0d", p), 64'(rd_hazard[p]), 64'(e_haz[p]));
    end
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b0;
    idle();
    model_reset();

    #12;
    chk("rst_valid",  64'(rd_valid),  64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_data",   rd_data,        64'd0);
    chk("rst_hazard", 64'(rd_hazard), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fresh register reads as zero
    idle(); rd(0, 5'd5); step();
    chk("r5_data",  64'(rd_data[31:0]), 64'd0);
    chk("r5_valid", 64'(rd_valid[0]),   64'd1);
    chk("r5_haz",   64'(rd_hazard[0]),  64'd0);

    idle(); setw(0, 5'd3, 32'hDEADBEEF); step();
    idle(); rd(0, 5'd3); rd(1, 5'd3); step();
    chk("r3_both", rd_data, 64'hDEADBEEF_DEADBEEF);

    // Same-address double write with same-cycle read
    idle(); setw(0, 5'd7, 32'h11); setw(1, 5'd7, 32'h22); rd(0, 5'd7); step();
    chk("r7_bypass", 64'(rd_data[31:0]), 64'h22);
    idle(); rd(1, 5'd7); step();
    chk("r7_later", 64'(rd_data[63:32]), 64'h22);
    chk("r7_valid", 64'(rd_valid), 64'b10);

    idle(); setw(0, 5'd0, 32'hFFFF_FFFF); resv_en = 1'b1; resv_addr = 5'd0; step();
    chk("r0_busy", 64'(busy[0]), 64'd0);
    idle(); rd(0, 5'd0); step();
    chk("r0_data", 64'(rd_data[31:0]), 64'd0);
    chk("r0_haz",  64'(rd_hazard[0]),  64'd0);

    idle(); resv_en = 1'b1; resv_addr = 5'd9; step();
    chk("r9_busy", 64'(busy[9]), 64'd1);
    idle(); rd(0, 5'd9); step();
    chk("r9_haz", 64'(rd_hazard[0]), 64'd1);
    idle(); rd(1, 5'd9); setw(1, 5'd9, 32'hABC); step();
    chk("r9_wr_haz",  64'(rd_hazard[1]),    64'd0);
    chk("r9_wr_data", 64'(rd_data[63:32]),  64'hABC);
    idle(); resv_en = 1'b1; resv_addr = 5'd9; step();
    idle(); resv_en = 1'b1; resv_addr = 5'd9; setw(0, 5'd9, 32'h55); step();
    chk("r9_setclr", 64'(busy[9]), 64'd1);
    idle(); setw(1, 5'd9, 32'h66); step();
    chk("r9_clear", 64'(busy[9]), 64'd0);

    // Out-of-range address and the last valid register
    idle(); setw(0, 5'd30, 32'h123); resv_en = 1'b1; resv_addr = 5'd30; rd(0, 5'd30); step();
    chk("r30_data", 64'(rd_data[31:0]), 64'd0);
    chk("r30_haz",  64'(rd_hazard[0]),  64'd0);
    idle(); setw(1, 5'd27, 32'hCAFE); step();
    idle(); rd(0, 5'd27); rd(1, 5'd30); step();
    chk("r27_data", rd_data, 64'h00000000_0000CAFE);

    for (int i = 0; i < 40; i++) begin
      idle();
      rd_en = 2'(i);
      rd_addr[4:0] = 5'((i * 7) % 32);
      rd_addr[9:5] = 5'((i * 11 + 3) % 32);
      if (i % 3 != 0) setw(0, 5'((i * 5) % 32), 32'(i) * 32'h01010101);
      if (i % 4 == 0) setw(1, 5'((i * 13) % 32), ~32'(i));
      if (i % 5 == 0) begin resv_en = 1'b1; resv_addr = 5'((i * 3) % 32); end
      step();
    end

    // Asynchronous reset between edges
    idle(); resv_en = 1'b1; resv_addr = 5'd12; rd(0, 5'd3); rd(1, 5'd12); step();
    #2 rst = 1'b0;
    #1;
    chk("mid_valid",  64'(rd_valid),  64'd0);
    chk("mid_busy",   64'(busy),      64'd0);
    chk("mid_data",   rd_data,        64'd0);
    chk("mid_hazard", 64'(rd_hazard), 64'd0);
    model_reset();
    #2 rst = 1'b1;
    idle(); step();
    idle(); rd(0, 5'd3); step();
    chk("post_rst_r3", 64'(rd_data[31:0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
